// File: rtl/chip8_rom_loader.sv
// chip8_rom_loader: streams a game image into Chip-8 memory port A starting
// at BASE_ADDR. The CPU is held in reset for the whole load, and stays held
// if the load fails.
// Optional build macro CHIP8_LOADER_VERIFY_EN adds a read-back checksum pass
// after the last byte. The default build has no verify state.
module chip8_rom_loader #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] length
);

`ifdef CHIP8_LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;

`ifdef CHIP8_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] vcnt;     // reads issued so far
    logic              rd_pend;  // a read was issued last cycle; its data is on mem_rdata
    logic [7:0]        vsum;
`else
    logic              unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // Memory port A: load writes pass straight through so a byte lands every cycle
    always_comb begin
        in_ready  = (state == S_LOAD);
        mem_en    = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_LOAD) begin
            mem_en    = in_valid;
            mem_write = in_valid;
            mem_addr  = addr;
            mem_wdata = in_data;
        end
`ifdef CHIP8_LOADER_VERIFY_EN
        else if (state == S_VERIFY && vcnt != length) begin
            mem_en   = 1'b1;
            mem_addr = BASE_ADDR + vcnt;
        end
`endif
    end

    // Load sequencer with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            sum      <= '0;
            length   <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
`ifdef CHIP8_LOADER_VERIFY_EN
            vcnt     <= '0;
            rd_pend  <= 1'b0;
            vsum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LOAD;
                        addr     <= BASE_ADDR;
                        sum      <= '0;
                        length   <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= 2'd0;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        addr   <= addr + 1'b1;
                        length <= length + 1'b1;
                        sum    <= sum + in_data;
                        if (in_last) begin
`ifdef CHIP8_LOADER_VERIFY_EN
                            state   <= S_VERIFY;
                            vcnt    <= '0;
                            rd_pend <= 1'b0;
                            vsum    <= '0;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
`endif
                        end else if (addr == {ADDR_W{1'b1}}) begin
                            // Top of memory reached without end-of-image: the byte
                            // is written, then the load is refused.
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= 2'd1;
                            busy     <= 1'b0;
                        end
                    end
                end
`ifdef CHIP8_LOADER_VERIFY_EN
                S_VERIFY: begin
                    if (rd_pend)
                        vsum <= vsum + mem_rdata;
                    rd_pend <= (vcnt != length);
                    if (vcnt != length) begin
                        vcnt <= vcnt + 1'b1;
                    end else if (!rd_pend) begin
                        // All read data folded in last cycle; decide now.
                        busy <= 1'b0;
                        if (vsum == sum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= 2'd2;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Bench for chip8_rom_loader: a byte-wide memory model, a write scoreboard
// filled by the stream driver and drained by a write monitor, plus status checks.
module tb_chip8_rom_loader;

    localparam logic [11:0] BASE = 12'h200;
`ifdef CHIP8_LOADER_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic        clk, rst, start;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic        mem_en, mem_write;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        cpu_hold, busy, done, error;
    logic [1:0]  err_code;
    logic [11:0] length;

    chip8_rom_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .length(length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory model: registered read, optional corruption of 0x201 on write
    logic [7:0] mem [0:4095];
    bit corrupt = 1'b0;
    always @(posedge clk) begin
        if (mem_en && mem_write)
            mem[mem_addr] <= (corrupt && mem_addr == 12'h201) ? 8'h06 : mem_wdata;
        if (mem_en && !mem_write)
            mem_rdata <= mem[mem_addr];
    end

    // Scoreboard of expected writes {addr, data}
    logic [19:0] sb_q [$];
    logic [11:0] exp_addr;
    logic [11:0] last_waddr = '0;

    always @(negedge clk) begin
        if (!rst && mem_en && mem_write) begin
            chk("wr_in_load", 32'(in_ready), 32'd1);
            if (sb_q.size() == 0) begin
                chk("wr_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [19:0] e;
                e = sb_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[19:8]));
                chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
                last_waddr = mem_addr;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        exp_addr = BASE;
    endtask

    task automatic send(input logic v, input logic [7:0] d, input logic l, output bit acc);
        @(posedge clk); #1;
        in_valid = v; in_data = d; in_last = l;
        acc = v && in_ready;
        if (acc) begin
            sb_q.push_back({exp_addr, d});
            exp_addr = exp_addr + 12'd1;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Cycles from the last accept edge until done/error appears
    task automatic wait_end(output int n);
        idle();
        n = 0;
        while (!(done || error) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("wait_timeout", 32'(n), 32'd0);
    endtask

    logic [7:0] img [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    task automatic load4(input string tag);
        bit acc;
        int n;
        pulse_start();
        for (int i = 0; i < 4; i++) send(1'b1, img[i], i == 3, acc);
        wait_end(n);
        chk({tag, "_lat"}, 32'(n), 32'(VER ? 6 : 0));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_len"}, 32'(length), 32'd4);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) chk({tag, "_mem"}, 32'(mem[BASE + 12'(i)]), 32'(img[i]));
    endtask

    initial begin
        bit acc;
        int n, cyc, k, acc_n;
        logic v;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        exp_addr = BASE;
        #1;
        chk("rst_outs", {cpu_hold, busy, done, error, err_code, length, in_ready,
                         mem_en, mem_write, mem_addr, mem_wdata}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Contiguous stream
        load4("t1");

        // Gapped stream with a start pulse mid-load
        for (int i = 0; i < 4; i++) mem[BASE + 12'(i)] = 8'h00;
        pulse_start();
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd1);
        k = 0; cyc = 0;
        while (k < 4 && cyc < 40) begin
            v = (cyc % 3 == 0);
            send(v, img[k], (k == 3) && v, acc);
            start = (cyc == 2);
            if (acc) k++;
            cyc++;
        end
        start = 1'b0;
        wait_end(n);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_len", 32'(length), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_mem", 32'(mem[BASE + 12'(i)]), 32'(img[i]));

        // Overflow: 3585 bytes offered, no end-of-image
        pulse_start();
        acc_n = 0;
        for (int i = 0; i < 3585; i++) begin
            send(1'b1, 8'(i), 1'b0, acc);
            if (acc) acc_n++;
        end
        idle();
        chk("ov_accepted", 32'(acc_n), 32'd3584);
        chk("ov_last_addr", 32'(last_waddr), 32'hFFF);
        chk("ov_error", 32'(error), 32'd1);
        chk("ov_code", 32'(err_code), 32'd1);
        chk("ov_hold", 32'(cpu_hold), 32'd1);
        chk("ov_ready", 32'(in_ready), 32'd0);
        chk("ov_busy", 32'(busy), 32'd0);
        chk("ov_done", 32'(done), 32'd0);
        chk("ov_len", 32'(length), 32'd3584);
        chk("ov_sb_empty", 32'(sb_q.size()), 32'd0);

        // Retry from ERROR, then reset after 10 bytes
        pulse_start();
        chk("retry_err_clr", 32'(error), 32'd0);
        for (int i = 0; i < 10; i++) send(1'b1, 8'(8'hC0 + i), 1'b0, acc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {cpu_hold, busy, done, error, err_code, length, in_ready,
                             mem_en, mem_write, mem_addr, mem_wdata}, 32'd0);
        chk("rst_mid_mem", 32'(mem[BASE + 12'd9]), 32'hC9);
        @(posedge clk); #1 rst = 1'b0;
        load4("t4");

`ifdef CHIP8_LOADER_VERIFY_EN
        // Read-back checksum: corrupted then clean
        corrupt = 1'b1;
        pulse_start();
        send(1'b1, 8'hA0, 1'b0, acc);
        send(1'b1, 8'h05, 1'b1, acc);
        wait_end(n);
        chk("vf_bad_err", 32'(error), 32'd1);
        chk("vf_bad_code", 32'(err_code), 32'd2);
        chk("vf_bad_hold", 32'(cpu_hold), 32'd1);
        corrupt = 1'b0;
        pulse_start();
        send(1'b1, 8'hA0, 1'b0, acc);
        send(1'b1, 8'h05, 1'b1, acc);
        wait_end(n);
        chk("vf_ok_lat", 32'(n), 32'd4);
        chk("vf_ok_done", 32'(done), 32'd1);
        chk("vf_ok_code", 32'(err_code), 32'd0);
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case something stalls outside a bounded wait
    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
